// File: rtl/gt_rx_sync_ctrl_if.sv
// Signal bundle between the GT receive path and the link sync controller.
// The controller uses the slave modport; the GT/bench side uses master.
interface gt_rx_sync_ctrl_if;
  logic [31:0] gt_rx_data;
  logic [3:0]  gt_rx_ctrl;
  logic [3:0]  align_sel;
  logic        link_up;
  logic        gt_rx_reset;
  logic [15:0] loss_cnt;
  logic [15:0] err_total;

  modport master (
    output gt_rx_data, gt_rx_ctrl,
    input  align_sel, link_up, gt_rx_reset, loss_cnt, err_total
  );

  modport slave (
    input  gt_rx_data, gt_rx_ctrl,
    output align_sel, link_up, gt_rx_reset, loss_cnt, err_total
  );
endinterface

// File: rtl/gt_rx_sync_ctrl.sv
// K28.5 comma qualification, lane select and GT RX reset sequencing for a 4-byte GTX lane.
// Optional statistics counters are built when GT_RX_SYNC_STATS_EN is defined.
module gt_rx_sync_ctrl #(
  parameter int VERIFY_CNT = 4,
  parameter int ERR_MAX    = 8,
  parameter int TIMEOUT    = 65535,
  parameter int RST_PULSE  = 16
) (
  input  logic               rx_clk,
  input  logic               rst,
  gt_rx_sync_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {RESET_GT, HUNT, VERIFY, LOCKED} state_t;

  localparam logic [3:0]  VCNT_LOCK  = 4'(VERIFY_CNT);
  localparam logic [3:0]  ERR_LIM    = 4'(ERR_MAX);
  localparam logic [15:0] TMR_LAST   = 16'(TIMEOUT - 1);
  localparam logic [7:0]  PULSE_LAST = 8'(RST_PULSE - 1);

  state_t      state_reg, state_next;
  logic        pos_reg, pos_next;
  logic [3:0]  vcnt_reg, vcnt_next;
  logic [3:0]  ecnt_reg, ecnt_next;
  logic [15:0] tmr_reg, tmr_next;
  logic [7:0]  pcnt_reg, pcnt_next;
  logic [3:0]  align_sel_reg;
  logic        link_up_reg;
  logic        gt_rx_reset_reg;

  logic is_none, is_good0, is_good2, is_good, good_pos;
  logic lock_now, drop_now, err_event;

  assign is_none  = (bus.gt_rx_ctrl == 4'b0000);
  assign is_good0 = (bus.gt_rx_ctrl == 4'b0001) && (bus.gt_rx_data[7:0] == 8'hBC);
  assign is_good2 = (bus.gt_rx_ctrl == 4'b0100) && (bus.gt_rx_data[23:16] == 8'hBC);
  assign is_good  = is_good0 || is_good2;
  assign good_pos = is_good2;

  // tmr_reg doubles as the hunt budget in HUNT/VERIFY and the comma-silence watchdog in LOCKED.
  always_comb begin
    state_next = state_reg;
    pos_next   = pos_reg;
    vcnt_next  = vcnt_reg;
    ecnt_next  = ecnt_reg;
    tmr_next   = tmr_reg;
    pcnt_next  = pcnt_reg;
    lock_now   = 1'b0;
    drop_now   = 1'b0;
    err_event  = 1'b0;
    case (state_reg)
      RESET_GT: begin
        if (pcnt_reg == PULSE_LAST) begin
          state_next = HUNT;
          pcnt_next  = '0;
          tmr_next   = '0;
        end else begin
          pcnt_next = pcnt_reg + 8'd1;
        end
      end
      HUNT, VERIFY: begin
        tmr_next = tmr_reg + 16'd1;
        if (tmr_reg == TMR_LAST) begin
          state_next = RESET_GT;
          pcnt_next  = '0;
          vcnt_next  = '0;
        end else if (state_reg == HUNT) begin
          if (is_good) begin
            pos_next   = good_pos;
            vcnt_next  = 4'd1;
            state_next = VERIFY;
            lock_now   = (VCNT_LOCK == 4'd1);
          end
        end else if (is_good && (good_pos == pos_reg)) begin
          vcnt_next = vcnt_reg + 4'd1;
          lock_now  = (vcnt_next == VCNT_LOCK);
        end else if (!is_none) begin
          // Mismatched or bad comma: restart hunting without re-capturing this word.
          state_next = HUNT;
          vcnt_next  = '0;
        end
      end
      LOCKED: begin
        if (is_good && (good_pos == pos_reg)) begin
          ecnt_next = '0;
          tmr_next  = '0;
        end else begin
          tmr_next = tmr_reg + 16'd1;
          if (!is_none) begin
            err_event = 1'b1;
            ecnt_next = ecnt_reg + 4'd1;
          end
          drop_now = (ecnt_next == ERR_LIM) || (tmr_reg == TMR_LAST);
        end
      end
      default: state_next = HUNT;
    endcase
    if (lock_now) begin
      state_next = LOCKED;
      vcnt_next  = '0;
      ecnt_next  = '0;
      tmr_next   = '0;
    end
    if (drop_now) begin
      state_next = HUNT;
      vcnt_next  = '0;
      ecnt_next  = '0;
      tmr_next   = '0;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state_reg       <= HUNT;
      pos_reg         <= 1'b0;
      vcnt_reg        <= '0;
      ecnt_reg        <= '0;
      tmr_reg         <= '0;
      pcnt_reg        <= '0;
      align_sel_reg   <= 4'b0000;
      link_up_reg     <= 1'b0;
      gt_rx_reset_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pos_reg         <= pos_next;
      vcnt_reg        <= vcnt_next;
      ecnt_reg        <= ecnt_next;
      tmr_reg         <= tmr_next;
      pcnt_reg        <= pcnt_next;
      link_up_reg     <= (state_next == LOCKED);
      gt_rx_reset_reg <= (state_next == RESET_GT);
      if (state_next == LOCKED)
        align_sel_reg <= pos_next ? 4'b0100 : 4'b0001;
      else
        align_sel_reg <= 4'b0000;
    end
  end

  assign bus.align_sel   = align_sel_reg;
  assign bus.link_up     = link_up_reg;
  assign bus.gt_rx_reset = gt_rx_reset_reg;

`ifdef GT_RX_SYNC_STATS_EN
  logic [15:0] loss_cnt_reg;
  logic [15:0] err_total_reg;
  logic        unused_bits;

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      loss_cnt_reg  <= '0;
      err_total_reg <= '0;
    end else begin
      if (drop_now && (loss_cnt_reg != 16'hFFFF))
        loss_cnt_reg <= loss_cnt_reg + 16'd1;
      if (err_event && (err_total_reg != 16'hFFFF))
        err_total_reg <= err_total_reg + 16'd1;
    end
  end

  assign bus.loss_cnt  = loss_cnt_reg;
  assign bus.err_total = err_total_reg;
  assign unused_bits   = ^{bus.gt_rx_data[31:24], bus.gt_rx_data[15:8]};
`else
  logic unused_bits;

  assign bus.loss_cnt  = 16'd0;
  assign bus.err_total = 16'd0;
  assign unused_bits   = ^{bus.gt_rx_data[31:24], bus.gt_rx_data[15:8], err_event};
`endif

endmodule

// File: tb/tb_gt_rx_sync_ctrl.sv
// Bench for gt_rx_sync_ctrl: directed scenarios then randomized traffic,
// every cycle compared against a cycle-count reference model.
module tb_gt_rx_sync_ctrl;
  localparam int VERIFY_CNT = 4;
  localparam int ERR_MAX    = 3;
  localparam int TIMEOUT    = 100;
  localparam int RST_PULSE  = 8;

  logic rx_clk = 1'b0;
  logic rst    = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  gt_rx_sync_ctrl_if bus ();

  gt_rx_sync_ctrl #(
    .VERIFY_CNT (VERIFY_CNT),
    .ERR_MAX    (ERR_MAX),
    .TIMEOUT    (TIMEOUT),
    .RST_PULSE  (RST_PULSE)
  ) dut (
    .rx_clk (rx_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 rx_clk = ~rx_clk;

  // Model: pos is the comma class code (1 = byte 0, 2 = byte 2), 0 when none.
  int m_pulse, m_locked, m_pos, m_streak, m_hunt, m_err_run, m_silent, m_loss, m_errtot;

  function automatic int classify(input logic [31:0] d, input logic [3:0] c);
    if (c == 4'b0000) return 0;
    if (c == 4'b0001 && d[7:0] == 8'hBC) return 1;
    if (c == 4'b0100 && d[23:16] == 8'hBC) return 2;
    return 3;
  endfunction

  task automatic model_step(input logic r, input int c);
    if (r) begin
      m_pulse = 0; m_locked = 0; m_pos = 0; m_streak = 0; m_hunt = 0;
      m_err_run = 0; m_silent = 0; m_loss = 0; m_errtot = 0;
    end else if (m_pulse > 0) begin
      m_pulse--;
      if (m_pulse == 0) m_hunt = 0;
    end else if (m_locked != 0) begin
      if (c == m_pos) begin
        m_err_run = 0;
        m_silent  = 0;
      end else begin
        m_silent++;
        if (c != 0) begin
          m_err_run++;
          if (m_errtot < 65535) m_errtot++;
        end
        if (m_err_run >= ERR_MAX || m_silent >= TIMEOUT) begin
          m_locked = 0; m_pos = 0; m_streak = 0; m_hunt = 0;
          m_err_run = 0; m_silent = 0;
          if (m_loss < 65535) m_loss++;
        end
      end
    end else begin
      m_hunt++;
      if (m_hunt >= TIMEOUT) begin
        m_pulse = RST_PULSE; m_streak = 0; m_pos = 0;
      end else if (c == 1 || c == 2) begin
        if (m_streak == 0) begin
          m_pos = c; m_streak = 1;
        end else if (c == m_pos) begin
          m_streak++;
        end else begin
          m_streak = 0; m_pos = 0;
        end
        if (m_streak >= VERIFY_CNT) begin
          m_locked = 1; m_err_run = 0; m_silent = 0;
        end
      end else if (c == 3) begin
        m_streak = 0; m_pos = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [3:0]  e_align;
    logic [15:0] e_loss, e_err;
    e_align = (m_locked == 0) ? 4'b0000 : ((m_pos == 2) ? 4'b0100 : 4'b0001);
`ifdef GT_RX_SYNC_STATS_EN
    e_loss = 16'(m_loss);
    e_err  = 16'(m_errtot);
`else
    e_loss = 16'd0;
    e_err  = 16'd0;
`endif
    chk("align_sel",   {12'd0, bus.align_sel}, {12'd0, e_align});
    chk("link_up",     {15'd0, bus.link_up},   {15'd0, (m_locked != 0)});
    chk("gt_rx_reset", {15'd0, bus.gt_rx_reset}, {15'd0, (m_pulse > 0)});
    chk("loss_cnt",    bus.loss_cnt,  e_loss);
    chk("err_total",   bus.err_total, e_err);
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] c, input logic r);
    bus.gt_rx_data = d;
    bus.gt_rx_ctrl = c;
    rst = r;
    @(posedge rx_clk);
    cyc++;
    model_step(r, classify(d, c));
    #1;
    check_outputs();
  endtask

  // kind: 0 idle, 1 good byte 0, 2 good byte 2, 3 bad (ctrl 4'b0011)
  task automatic send(input int kind);
    logic [31:0] d;
    d = $urandom;
    case (kind)
      1: begin d[7:0] = 8'hBC;   drive(d, 4'b0001, 1'b0); end
      2: begin d[23:16] = 8'hBC; drive(d, 4'b0100, 1'b0); end
      3: drive(d, 4'b0011, 1'b0);
      default: drive(d, 4'b0000, 1'b0);
    endcase
  endtask

  task automatic do_reset();
    drive(32'd0, 4'd0, 1'b1);
    drive(32'd0, 4'd0, 1'b1);
  endtask

  initial begin
    int first_high, width, seen, mode, pref, other, r, rb;
    logic [31:0] d;
    logic [3:0]  ct;
    logic [15:0] e_stat;

    bus.gt_rx_data = '0;
    bus.gt_rx_ctrl = '0;

    // Reset state
    do_reset();
    chk("reset_link", {15'd0, bus.link_up}, 16'd0);
    $display("scenario reset checks=%0d", checks);

    // Lock at byte 0 with idles between commas
    for (int i = 0; i < 4; i++) begin
      send(1);
      if (i == 2) chk("lock0_early", {15'd0, bus.link_up}, 16'd0);
      if (i == 3) begin
        chk("lock0_link",  {15'd0, bus.link_up}, 16'd1);
        chk("lock0_align", {12'd0, bus.align_sel}, 16'h0001);
      end
      send(0);
    end
    $display("scenario lock_byte0 checks=%0d", checks);

    // Lock at byte 2 after an interrupting byte-0 comma
    do_reset();
    send(2); send(2); send(1);
    chk("lock2_interrupt", {15'd0, bus.link_up}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      send(2);
      if (i == 2) chk("lock2_early", {15'd0, bus.link_up}, 16'd0);
    end
    chk("lock2_link",  {15'd0, bus.link_up}, 16'd1);
    chk("lock2_align", {12'd0, bus.align_sel}, 16'h0004);
    $display("scenario lock_byte2 checks=%0d", checks);

    // Bad commas broken by a good one keep the link; three in a row drop it
    send(3); send(3); send(2); send(3); send(3);
    chk("loss_hold", {15'd0, bus.link_up}, 16'd1);
    send(2);
    send(3); send(3);
    chk("loss_hold2", {15'd0, bus.link_up}, 16'd1);
    send(3);
    chk("loss_drop", {15'd0, bus.link_up}, 16'd0);
    chk("loss_align", {12'd0, bus.align_sel}, 16'd0);
`ifdef GT_RX_SYNC_STATS_EN
    e_stat = 16'd1;
`else
    e_stat = 16'd0;
`endif
    chk("loss_cnt_one", bus.loss_cnt, e_stat);
    $display("scenario loss_of_lock checks=%0d", checks);

    // Hunt timeout and GT reset pulse, then relock
    do_reset();
    first_high = -1;
    width = 0;
    for (int k = 1; k <= 130; k++) begin
      send(0);
      if (bus.gt_rx_reset === 1'b1) begin
        if (first_high < 0) first_high = k;
        width++;
      end
    end
    chk("pulse_start", 16'(first_high), 16'd100);
    chk("pulse_width", 16'(width), 16'd8);
    for (int i = 0; i < 4; i++) send(1);
    chk("relock_link", {15'd0, bus.link_up}, 16'd1);
    $display("scenario hunt_timeout checks=%0d", checks);

    // Comma-silence watchdog in LOCKED
    for (int k = 1; k <= 100; k++) begin
      send(0);
      if (k == 99) chk("wdog_hold", {15'd0, bus.link_up}, 16'd1);
    end
    chk("wdog_drop", {15'd0, bus.link_up}, 16'd0);
    chk("wdog_loss", bus.loss_cnt, e_stat);
    $display("scenario watchdog checks=%0d", checks);

    // Reset in the third cycle of the GT reset pulse
    do_reset();
    seen = 0;
    for (int k = 0; k < 200 && seen == 0; k++) begin
      send(0);
      if (bus.gt_rx_reset === 1'b1) seen = 1;
    end
    chk("pulse_seen", 16'(seen), 16'd1);
    send(0); send(0);
    drive(32'd0, 4'd0, 1'b1);
    chk("midpulse_reset", {15'd0, bus.gt_rx_reset}, 16'd0);
    chk("midpulse_loss", bus.loss_cnt, 16'd0);
    drive(32'd0, 4'd0, 1'b0);
    $display("scenario reset_mid_pulse checks=%0d", checks);

    // Randomized segments: quiet, clean, noisy and mixed traffic
    for (int s = 0; s < 20; s++) begin
      mode  = $urandom_range(0, 3);
      pref  = $urandom_range(1, 2);
      other = 3 - pref;
      for (int k = 0; k < 150; k++) begin
        r  = $urandom_range(0, 99);
        rb = ($urandom_range(0, 999) == 0) ? 1 : 0;
        d  = $urandom;
        ct = 4'b0000;
        case (mode)
          0: if (r < 3) ct = (pref == 1) ? 4'b0001 : 4'b0100;
          1: begin
            if (r < 40) ct = (pref == 1) ? 4'b0001 : 4'b0100;
            else if (r >= 97) ct = 4'(($urandom_range(1, 15)));
          end
          2: begin
            if (r < 30) ct = 4'b0000;
            else if (r < 55) ct = (pref == 1) ? 4'b0001 : 4'b0100;
            else if (r < 75) ct = (other == 1) ? 4'b0001 : 4'b0100;
            else ct = 4'(($urandom_range(1, 15)));
          end
          default: begin
            if (r < 60) ct = 4'b0000;
            else if (r < 85) ct = (pref == 1) ? 4'b0001 : 4'b0100;
            else if (r < 92) ct = (other == 1) ? 4'b0001 : 4'b0100;
            else ct = 4'b0011;
          end
        endcase
        // Usually place a real K28.5 on the flagged byte; sometimes leave junk
        if (r % 10 != 9) begin
          if (ct == 4'b0001) d[7:0] = 8'hBC;
          if (ct == 4'b0100) d[23:16] = 8'hBC;
        end
        drive(d, ct, rb[0]);
      end
      $display("random segment %0d mode=%0d pref=%0d checks=%0d", s, mode, pref, checks);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gt_rx_sync_ctrl.md
# gt_rx_sync_ctrl

Receive-side link synchronisation controller for the 32-bit/4-byte GTX datapath, running in the `rx_clk` domain beside the comma-based word aligner. It watches raw `gt_rx_data`/`gt_rx_ctrl` for K28.5 commas and qualifies the comma byte position over several consecutive commas. It drives the aligner's lane select and declares `link_up`. On persistent loss of sync it issues a timed GT RX reset pulse.

## Interface
- `VERIFY_CNT`, default 4: consecutive consistent commas required to lock (1..15).
- `ERR_MAX`, default 8: consecutive bad commas in LOCKED that drop lock (1..15).
- `TIMEOUT`, default 65535: cycle budget for hunting, and the comma-silence watchdog in LOCKED (2..65535).
- `RST_PULSE`, default 16: `gt_rx_reset` pulse width in cycles (1..255).
- `rx_clk` in 1: sole clock; recovered RX user clock.
- `rst` in 1: synchronous, active-high reset.
- `gt_rx_data` in 32: raw GT RX data, byte 0 = [7:0].
- `gt_rx_ctrl` in 4: raw GT RX K-flags, bit n marks byte n.
- `align_sel` out 4: lane select to aligner; 4'b0001, 4'b0100 or 4'b0000.
- `link_up` out 1: high only in LOCKED.
- `gt_rx_reset` out 1: GT RX datapath reset request.
- `loss_cnt` out 16: saturating count of LOCKED→HUNT transitions.
- `err_total` out 16: saturating count of bad commas seen in LOCKED.

## Operation
- Comma classification is combinational on the current input word:
  - none: `gt_rx_ctrl`==0.
  - good0: ctrl==4'b0001 and data[7:0]==8'hBC.
  - good2: ctrl==4'b0100 and data[23:16]==8'hBC.
  - bad: any other nonzero ctrl.
- States: RESET_GT, HUNT, VERIFY, LOCKED. On `rst` the FSM enters HUNT with all counters cleared.
- HUNT
  - good0/good2: capture position `pos`, vcnt=1, go to VERIFY. If VERIFY_CNT==1, go directly to LOCKED.
- VERIFY
  - good comma with the same `pos`: vcnt+1. When vcnt reaches VERIFY_CNT, go to LOCKED.
  - good comma with a different `pos`, or bad: return to HUNT with vcnt=0 (the same cycle does not re-capture).
  - none: hold.
- HUNT/VERIFY share a 16-bit `hunt_tmr`.
  - It clears on entry to HUNT from LOCKED or RESET_GT and increments every cycle in HUNT/VERIFY.
  - At `hunt_tmr`==TIMEOUT-1 the FSM goes to RESET_GT. The timeout wins over a simultaneous lock.
- RESET_GT: `gt_rx_reset`=1 for exactly RST_PULSE cycles, then HUNT.
- LOCKED
  - good comma at the locked `pos`: clears `ecnt` and the watchdog.
  - bad, or good at the other position: `ecnt`+1 and `err_total`+1.
  - `ecnt` reaching ERR_MAX: go to HUNT and increment `loss_cnt`.
  - Watchdog reaching TIMEOUT-1 with no good comma: go to HUNT and increment `loss_cnt`.
- `align_sel` = one-hot of `pos` in LOCKED, 4'b0000 otherwise. The aligner therefore outputs zeros until lock.
- Counters saturate at 16'hFFFF.

## Timing
- All outputs are registered. Reset values: `align_sel`=0, `link_up`=0, `gt_rx_reset`=0, `loss_cnt`=0, `err_total`=0.
- Lock latency: the VERIFY_CNT-th good comma is sampled at edge N; `link_up`/`align_sel` are valid after edge N (first high cycle N+1).
- Loss latency: the ERR_MAX-th bad comma is sampled at edge N; `link_up` falls and `align_sel`=0 after edge N.
- `gt_rx_reset` rises the cycle after the timeout edge and is high for RST_PULSE cycles. HUNT resumes the cycle after it falls.
- `rst` mid-operation, including mid-pulse: all outputs return to reset values on the next edge, and `gt_rx_reset` drops immediately at that edge.
- Inputs are used unregistered on the same edge; no input pipeline.

## Configuration
- `GT_RX_SYNC_STATS_EN`:
  - Defined: `loss_cnt` and `err_total` counters are implemented as described.
  - Undefined: the counters are not built, both ports are tied to 16'd0, and FSM behaviour is identical.

## Test plan
All scenarios use VERIFY_CNT=4, ERR_MAX=3, TIMEOUT=100, RST_PULSE=8.
- Lock at byte 0: after reset, drive 4 words {data=32'h000000BC, ctrl=4'b0001} spaced by idle ctrl=0 words → `link_up`=1 and `align_sel`=4'b0001 from the cycle after the 4th comma.
- Lock at byte 2 with interruption: good2 ×2, then good0, then good2 ×4 → no lock until the 4th good2 after the good0; then `align_sel`=4'b0100.
- Loss of lock: after lock, 3 consecutive ctrl=4'b0011 words → `link_up`=0 the next cycle, `loss_cnt`=1, `err_total`=3. A good comma between bad ones resets `ecnt` and the link stays up.
- Hunt timeout: only ctrl=0 for 100 cycles after reset → `gt_rx_reset` high for exactly 8 cycles, then low; a lock succeeds afterwards.
- Watchdog: after lock, 100 cycles of ctrl=0 → `link_up` drops and `loss_cnt` increments.
- Reset mid-pulse: assert `rst` during cycle 3 of `gt_rx_reset` → all outputs 0 next cycle; stats are zero with `GT_RX_SYNC_STATS_EN` undefined.
